// File: rtl/hacd_pkg.sv
// Shared types for the hawk ATT lookup handshake: request/response packets,
// ATT entry state encodings and the responder FSM state enum.
package hacd_pkg;

    localparam int HACD_HPPA_W     = 40;
    localparam int HACD_PPA_W      = 40;
    localparam int ATT_ENTRY_BYTES = 8;
    localparam int ATT_ENTRY_SHIFT = $clog2(ATT_ENTRY_BYTES);

    localparam logic [1:0] ATT_UNALLOC    = 2'b00;
    localparam logic [1:0] ATT_MAPPED     = 2'b01;
    localparam logic [1:0] ATT_COMPRESSED = 2'b10;
    localparam logic [1:0] ATT_RSVD       = 2'b11;

    typedef struct packed {
        logic                   lookup;
        logic [HACD_HPPA_W-1:0] hppa;
    } att_lkup_reqpkt_t;

    typedef struct packed {
        logic                  allow_access;
        logic                  tbl_update;
        logic [HACD_PPA_W-1:0] ppa;
    } trnsl_reqpkt_t;

    typedef enum logic [2:0] {
        RSP_IDLE,
        RSP_ISSUE,
        RSP_WAIT_RSP,
        RSP_DECODE,
        RSP_ALLOC,
        RSP_UPD_WAIT,
        RSP_GRANT
    } rsp_state_e;

endpackage

// File: rtl/hawk_att_entry_decode.sv
// Combinational split of a 64-bit ATT entry into state, ppa and an error flag
// for states the responder cannot serve directly (compressed, reserved).
module hawk_att_entry_decode
    import hacd_pkg::*;
#(
    parameter int PPA_W = HACD_PPA_W
) (
    input  logic [63:0]      entry_i,
    output logic [1:0]       state_o,
    output logic [PPA_W-1:0] ppa_o,
    output logic             err_o
);

    logic unused_entry_bits;

    assign state_o = entry_i[63:62];
    assign ppa_o   = entry_i[PPA_W-1:0];
    assign err_o   = (state_o == ATT_COMPRESSED) || (state_o == ATT_RSVD);

    assign unused_entry_bits = ^entry_i[61:PPA_W];

endmodule

// File: rtl/hawk_att_lkup_responder.sv
// Responder for ATT lookups: reads and decodes the entry, allocates on a miss,
// grants access. Define HAWK_ATT_LKUP_CACHE_EN for a one-entry translation cache.
module hawk_att_lkup_responder
    import hacd_pkg::*;
#(
    parameter int          HPPA_W   = HACD_HPPA_W,
    parameter int          PPA_W    = HACD_PPA_W,
    parameter int          MEM_AW   = 64,
    parameter logic [63:0] ATT_BASE = 64'h0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  att_lkup_reqpkt_t  lkup_reqpkt,
    output logic              pgrd_mngr_ready,
    output trnsl_reqpkt_t     trnsl_reqpkt,
    output logic              mem_rd_req_valid,
    input  logic              mem_rd_req_ready,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic              mem_rd_rsp_valid,
    input  logic [63:0]       mem_rd_rsp_data,
    input  logic              free_head_valid,
    input  logic [PPA_W-1:0]  free_head_ppa,
    input  logic              tbl_update_done,
    output logic              decode_err
);

    rsp_state_e        state_q, state_d;
    logic              ready_q, ready_d;
    logic              req_valid_q, req_valid_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [63:0]       entry_q, entry_d;
    logic              allow_q, allow_d;
    logic              upd_q, upd_d;
    logic [PPA_W-1:0]  ppa_q, ppa_d;
    logic              decode_err_q, decode_err_d;

    logic [HPPA_W-1:0] req_hppa;
    logic [MEM_AW-1:0] entry_addr;
    logic [1:0]        dec_state;
    logic [PPA_W-1:0]  dec_ppa;
    logic              dec_err;

`ifdef HAWK_ATT_LKUP_CACHE_EN
    logic [HPPA_W-1:0] hppa_q, hppa_d;
    logic              cache_valid_q, cache_valid_d;
    logic [HPPA_W-1:0] cache_tag_q, cache_tag_d;
    logic [PPA_W-1:0]  cache_ppa_q, cache_ppa_d;
    logic              cache_hit;
`endif

    assign req_hppa   = lkup_reqpkt.hppa;
    // Address wraps silently at MEM_AW bits; the ATT is assumed to fit.
    assign entry_addr = MEM_AW'(ATT_BASE) + (MEM_AW'(req_hppa) << ATT_ENTRY_SHIFT);

    hawk_att_entry_decode #(
        .PPA_W (PPA_W)
    ) u_entry_decode (
        .entry_i (entry_q),
        .state_o (dec_state),
        .ppa_o   (dec_ppa),
        .err_o   (dec_err)
    );

`ifdef HAWK_ATT_LKUP_CACHE_EN
    assign cache_hit = cache_valid_q && (cache_tag_q == req_hppa);
`endif

    always_comb begin
        // NOTE: every *_d gets a default first so no path can infer a latch.
        state_d      = state_q;
        ready_d      = ready_q;
        req_valid_d  = req_valid_q;
        addr_d       = addr_q;
        entry_d      = entry_q;
        allow_d      = allow_q;
        upd_d        = upd_q;
        ppa_d        = ppa_q;
        decode_err_d = 1'b0;
`ifdef HAWK_ATT_LKUP_CACHE_EN
        hppa_d        = hppa_q;
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_ppa_d   = cache_ppa_q;
`endif

        unique case (state_q)
            RSP_IDLE: begin
                ready_d = 1'b1;
                if (lkup_reqpkt.lookup) begin
                    ready_d = 1'b0;
`ifdef HAWK_ATT_LKUP_CACHE_EN
                    hppa_d  = req_hppa;
                    if (cache_hit) begin
                        allow_d = 1'b1;
                        ppa_d   = cache_ppa_q;
                        state_d = RSP_GRANT;
                    end else
`endif
                    begin
                        req_valid_d = 1'b1;
                        addr_d      = entry_addr;
                        state_d     = RSP_ISSUE;
                    end
                end
            end
            RSP_ISSUE: begin
                if (mem_rd_req_ready) begin
                    req_valid_d = 1'b0;
                    addr_d      = '0;
                    state_d     = RSP_WAIT_RSP;
                end
            end
            RSP_WAIT_RSP: begin
                if (mem_rd_rsp_valid) begin
                    entry_d = mem_rd_rsp_data;
                    state_d = RSP_DECODE;
                end
            end
            RSP_DECODE: begin
                if (dec_state == ATT_MAPPED) begin
                    allow_d = 1'b1;
                    ppa_d   = dec_ppa;
                    state_d = RSP_GRANT;
                end else begin
                    // Compressed/reserved entries fall back to a fresh allocation.
                    decode_err_d = dec_err;
                    state_d      = RSP_ALLOC;
                end
            end
            RSP_ALLOC: begin
                if (free_head_valid) begin
                    upd_d   = 1'b1;
                    ppa_d   = free_head_ppa;
                    state_d = RSP_UPD_WAIT;
                end
            end
            RSP_UPD_WAIT: begin
                if (tbl_update_done) begin
                    upd_d   = 1'b0;
                    allow_d = 1'b1;
                    state_d = RSP_GRANT;
                end
            end
            RSP_GRANT: begin
                if (!lkup_reqpkt.lookup) begin
                    allow_d = 1'b0;
                    ppa_d   = '0;
                    ready_d = 1'b1;
                    state_d = RSP_IDLE;
                end
            end
            default: state_d = RSP_IDLE;
        endcase

`ifdef HAWK_ATT_LKUP_CACHE_EN
        if (state_d == RSP_GRANT && state_q != RSP_GRANT) begin
            cache_valid_d = 1'b1;
            cache_tag_d   = hppa_d;
            cache_ppa_d   = ppa_d;
        end
        // Invalidation wins over a same-cycle fill: freshly allocated pages are not cached.
        if (tbl_update_done) cache_valid_d = 1'b0;
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RSP_IDLE;
            ready_q      <= 1'b0;
            req_valid_q  <= 1'b0;
            addr_q       <= '0;
            entry_q      <= '0;
            allow_q      <= 1'b0;
            upd_q        <= 1'b0;
            ppa_q        <= '0;
            decode_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            req_valid_q  <= req_valid_d;
            addr_q       <= addr_d;
            entry_q      <= entry_d;
            allow_q      <= allow_d;
            upd_q        <= upd_d;
            ppa_q        <= ppa_d;
            decode_err_q <= decode_err_d;
        end
    end

`ifdef HAWK_ATT_LKUP_CACHE_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hppa_q        <= '0;
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_ppa_q   <= '0;
        end else begin
            hppa_q        <= hppa_d;
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_ppa_q   <= cache_ppa_d;
        end
    end
`endif

    assign pgrd_mngr_ready           = ready_q;
    assign mem_rd_req_valid          = req_valid_q;
    assign mem_rd_addr               = addr_q;
    assign decode_err                = decode_err_q;
    assign trnsl_reqpkt.allow_access = allow_q;
    assign trnsl_reqpkt.tbl_update   = upd_q;
    assign trnsl_reqpkt.ppa          = ppa_q;

endmodule

// File: tb/tb_hawk_att_lkup_responder.sv
// Directed bench for hawk_att_lkup_responder: hit, miss, backpressure, empty
// free list, compressed entry, mid-transaction reset and the optional cache.
module tb_hawk_att_lkup_responder;
    import hacd_pkg::*;

    localparam logic [63:0] BASE = 64'h1000;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    att_lkup_reqpkt_t lkup_reqpkt;
    logic             pgrd_mngr_ready;
    trnsl_reqpkt_t    trnsl_reqpkt;
    logic             mem_rd_req_valid;
    logic             mem_rd_req_ready;
    logic [63:0]      mem_rd_addr;
    logic             mem_rd_rsp_valid;
    logic [63:0]      mem_rd_rsp_data;
    logic             free_head_valid;
    logic [HACD_PPA_W-1:0] free_head_ppa;
    logic             tbl_update_done;
    logic             decode_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model / monitor state (written only by the model process).
    int          req_count   = 0;
    int          rsp_count   = 0;
    int          err_cycles  = 0;
    int          excl_cycles = 0;
    int          stall_left  = 0;
    int          cnt         = 0;
    bit          pending     = 1'b0;
    logic [63:0] last_addr   = 64'h0;

    // Memory model configuration (written only by the main process).
    int          stall_cfg = 0;
    int          rsp_delay = 0;
    logic [63:0] mem_entry = 64'h0;

    hawk_att_lkup_responder #(
        .ATT_BASE (BASE)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .lkup_reqpkt      (lkup_reqpkt),
        .pgrd_mngr_ready  (pgrd_mngr_ready),
        .trnsl_reqpkt     (trnsl_reqpkt),
        .mem_rd_req_valid (mem_rd_req_valid),
        .mem_rd_req_ready (mem_rd_req_ready),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_rsp_valid (mem_rd_rsp_valid),
        .mem_rd_rsp_data  (mem_rd_rsp_data),
        .free_head_valid  (free_head_valid),
        .free_head_ppa    (free_head_ppa),
        .tbl_update_done  (tbl_update_done),
        .decode_err       (decode_err)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Memory responds rsp_delay cycles after the accepting edge (0 = next cycle).
    initial begin
        mem_rd_req_ready = 1'b1;
        mem_rd_rsp_valid = 1'b0;
        mem_rd_rsp_data  = 64'h0;
        forever begin
            @(negedge clk_i);
            if (decode_err) err_cycles++;
            if (trnsl_reqpkt.allow_access && trnsl_reqpkt.tbl_update) excl_cycles++;
            mem_rd_rsp_valid = 1'b0;
            mem_rd_rsp_data  = 64'h0;
            if (pending) begin
                if (cnt == 0) begin
                    mem_rd_rsp_valid = 1'b1;
                    mem_rd_rsp_data  = mem_entry;
                    pending          = 1'b0;
                    rsp_count++;
                end else begin
                    cnt--;
                end
            end
            if (!mem_rd_req_valid) stall_left = stall_cfg;
            if (mem_rd_req_valid && stall_left > 0) begin
                mem_rd_req_ready = 1'b0;
                stall_left--;
            end else begin
                mem_rd_req_ready = 1'b1;
            end
            if (mem_rd_req_valid && mem_rd_req_ready) begin
                pending   = 1'b1;
                cnt       = rsp_delay;
                last_addr = mem_rd_addr;
                req_count++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_lookup(input logic [HACD_HPPA_W-1:0] h);
        @(negedge clk_i);
        lkup_reqpkt.lookup = 1'b1;
        lkup_reqpkt.hppa   = h;
    endtask

    // Returns the number of edges from the lookup-sampling edge until the
    // requested response is seen, or -1 when the bound expires.
    task automatic wait_resp(input bit want_upd, input int max, output int cyc);
        bit hit = 1'b0;
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            if (!hit) begin
                @(negedge clk_i);
                if ((want_upd ? trnsl_reqpkt.tbl_update : trnsl_reqpkt.allow_access) === 1'b1) begin
                    hit = 1'b1;
                    cyc = i;
                end
            end
        end
    endtask

    task automatic end_lookup(input string tag);
        @(negedge clk_i);
        lkup_reqpkt.lookup = 1'b0;
        @(negedge clk_i);
        check({tag, "_end_allow"}, 64'(trnsl_reqpkt.allow_access), 64'h0);
        check({tag, "_end_ppa"},   64'(trnsl_reqpkt.ppa),          64'h0);
        check({tag, "_end_ready"}, 64'(pgrd_mngr_ready),           64'h1);
    endtask

    task automatic pulse_done();
        @(negedge clk_i);
        tbl_update_done = 1'b1;
        @(negedge clk_i);
        tbl_update_done = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        int rc0;
        int e0;
        int r0;

        lkup_reqpkt     = '0;
        free_head_valid = 1'b0;
        free_head_ppa   = '0;
        tbl_update_done = 1'b0;

        repeat (2) @(negedge clk_i);
        check("rst_ready",     64'(pgrd_mngr_ready),  64'h0);
        check("rst_rsp",       64'(trnsl_reqpkt),     64'h0);
        check("rst_req_valid", 64'(mem_rd_req_valid), 64'h0);
        check("rst_addr",      mem_rd_addr,           64'h0);
        check("rst_err",       64'(decode_err),       64'h0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        check("idle_ready",    64'(pgrd_mngr_ready),  64'h1);

        // Mapped hit, zero wait states.
        mem_entry = 64'h4000_0000_0000_00AB;
        start_lookup(40'h12);
        wait_resp(1'b0, 20, lat);
        check("hit_latency", 64'(lat), 64'd4);
        check("hit_ppa",     64'(trnsl_reqpkt.ppa),        64'hAB);
        check("hit_upd",     64'(trnsl_reqpkt.tbl_update), 64'h0);
        check("hit_addr",    last_addr,                    64'h1090);
        check("hit_busy",    64'(pgrd_mngr_ready),         64'h0);
        repeat (3) @(negedge clk_i);
        check("hit_hold_allow", 64'(trnsl_reqpkt.allow_access), 64'h1);
        check("hit_hold_ppa",   64'(trnsl_reqpkt.ppa),          64'hAB);
        end_lookup("hit");

        // Miss with allocation.
        mem_entry       = 64'h0;
        free_head_valid = 1'b1;
        free_head_ppa   = 40'h77;
        start_lookup(40'h20);
        wait_resp(1'b1, 20, lat);
        check("miss_upd",   64'(trnsl_reqpkt.tbl_update),   64'h1);
        check("miss_ppa",   64'(trnsl_reqpkt.ppa),          64'h77);
        check("miss_allow", 64'(trnsl_reqpkt.allow_access), 64'h0);
        repeat (4) @(negedge clk_i);
        check("miss_upd_held", 64'(trnsl_reqpkt.tbl_update), 64'h1);
        check("miss_ppa_held", 64'(trnsl_reqpkt.ppa),        64'h77);
        pulse_done();
        wait_resp(1'b0, 5, lat);
        check("miss_grant",     64'(trnsl_reqpkt.allow_access), 64'h1);
        check("miss_grant_ppa", 64'(trnsl_reqpkt.ppa),          64'h77);
        check("miss_grant_upd", 64'(trnsl_reqpkt.tbl_update),   64'h0);
        end_lookup("miss");

        // Backpressure: 3 stalled request cycles, response 10 cycles late.
        stall_cfg = 3;
        rsp_delay = 10;
        mem_entry = 64'h4000_0000_0000_00CD;
        rc0       = req_count;
        start_lookup(40'h33);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("bp_valid", 64'(mem_rd_req_valid), 64'h1);
            check("bp_addr",  mem_rd_addr,           64'h1198);
        end
        wait_resp(1'b0, 40, lat);
        check("bp_latency", 64'(lat + 3),            64'd17);
        check("bp_one_req", 64'(req_count - rc0),    64'd1);
        check("bp_ppa",     64'(trnsl_reqpkt.ppa),   64'hCD);
        end_lookup("bp");
        stall_cfg = 0;
        rsp_delay = 0;

        // Empty free list for 20 cycles.
        free_head_valid = 1'b0;
        mem_entry       = 64'h0;
        start_lookup(40'h44);
        repeat (4) @(negedge clk_i);
        seen = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (trnsl_reqpkt.tbl_update) seen++;
        end
        check("fe_no_upd", 64'(seen),            64'd0);
        check("fe_busy",   64'(pgrd_mngr_ready), 64'h0);
        free_head_valid = 1'b1;
        free_head_ppa   = 40'h5;
        wait_resp(1'b1, 5, lat);
        check("fe_latency", 64'(lat),                     64'd1);
        check("fe_ppa",     64'(trnsl_reqpkt.ppa),        64'h5);
        pulse_done();
        wait_resp(1'b0, 5, lat);
        check("fe_grant",   64'(trnsl_reqpkt.allow_access), 64'h1);
        end_lookup("fe");

        // Compressed entry: one decode_err pulse, then allocation.
        e0 = err_cycles;
        check("no_err_before", 64'(e0), 64'd0);
        mem_entry     = 64'h8000_0000_0000_0033;
        free_head_ppa = 40'h9;
        start_lookup(40'h55);
        wait_resp(1'b1, 20, lat);
        check("cmp_latency",    64'(lat),              64'd5);
        check("cmp_err_pulses", 64'(err_cycles - e0),  64'd1);
        check("cmp_ppa",        64'(trnsl_reqpkt.ppa), 64'h9);
        pulse_done();
        wait_resp(1'b0, 5, lat);
        check("cmp_grant",      64'(trnsl_reqpkt.allow_access), 64'h1);
        end_lookup("cmp");

        // Reset while waiting for the read response; late response must be ignored.
        rsp_delay = 10;
        mem_entry = 64'h4000_0000_0000_00EE;
        r0        = rsp_count;
        start_lookup(40'h66);
        repeat (3) @(negedge clk_i);
        @(negedge clk_i);
        rst_ni             = 1'b0;
        lkup_reqpkt.lookup = 1'b0;
        #1;
        check("rr_rsp",   64'(trnsl_reqpkt),     64'h0);
        check("rr_valid", 64'(mem_rd_req_valid), 64'h0);
        check("rr_ready", 64'(pgrd_mngr_ready),  64'h0);
        check("rr_err",   64'(decode_err),       64'h0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        seen   = 0;
        repeat (14) begin
            @(negedge clk_i);
            if (trnsl_reqpkt.allow_access || trnsl_reqpkt.tbl_update || mem_rd_req_valid) seen++;
        end
        check("rr_no_resp",  64'(seen),            64'd0);
        check("rr_late_rsp", 64'(rsp_count - r0),  64'd1);
        rsp_delay = 0;
        mem_entry = 64'h4000_0000_0000_00AB;
        start_lookup(40'h12);
        wait_resp(1'b0, 20, lat);
        check("rr_next_latency", 64'(lat),              64'd4);
        check("rr_next_ppa",     64'(trnsl_reqpkt.ppa), 64'hAB);
        end_lookup("rr");

`ifdef HAWK_ATT_LKUP_CACHE_EN
        rc0 = req_count;
        start_lookup(40'h12);
        wait_resp(1'b0, 20, lat);
        check("c_hit_latency", 64'(lat),               64'd1);
        check("c_hit_ppa",     64'(trnsl_reqpkt.ppa),  64'hAB);
        check("c_no_read",     64'(req_count - rc0),   64'd0);
        end_lookup("c_hit");
        pulse_done();
        rc0 = req_count;
        start_lookup(40'h12);
        wait_resp(1'b0, 20, lat);
        check("c_inv_latency", 64'(lat),               64'd4);
        check("c_inv_read",    64'(req_count - rc0),   64'd1);
        end_lookup("c_inv");
`else
        rc0 = req_count;
        start_lookup(40'h12);
        wait_resp(1'b0, 20, lat);
        check("nc_latency", 64'(lat),             64'd4);
        check("nc_read",    64'(req_count - rc0), 64'd1);
        end_lookup("nc");
`endif

        check("mutual_excl", 64'(excl_cycles), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
